fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch controller that sits directly upstream of the 16-bit PC register.
- Drives the PC register's `in` with `pc_next` every cycle and reads back its `out` as `pc_cur`.
- Issues req/ack reads to instruction memory and hands fetched instructions to decode over a valid/ready interface.
- Applies branch redirects from execute, draining any in-flight memory access before fetching from the new target.

Parameters:
- ADDR_W, 16, width of PC and instruction-memory address.
- INSTR_W, 16, instruction width.
- PC_STEP, 1, PC increment per instruction (word addressing).
- RESET_PC, 0, fetch start address driven on `pc_next` during reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- pc_cur  input  ADDR_W  current PC (PC register `out`).
- pc_next  output  ADDR_W  next PC (PC register `in`); combinational.
- imem_req  output  1  memory request; held high until `imem_ack`.
- imem_addr  output  ADDR_W  request address (registered `addr_q`); stable while `imem_req` is high.
- imem_ack  input  1  one-cycle acknowledge; `imem_rdata` is valid in the same cycle.
- imem_rdata  input  INSTR_W  instruction data.
- branch_taken  input  1  one-cycle redirect pulse from execute.
- branch_target  input  ADDR_W  redirect address.
- if_valid  output  1  `if_instr`/`if_pc` are valid.
- if_instr  output  INSTR_W  fetched instruction.
- if_pc  output  ADDR_W  address of `if_instr`.
- id_ready  input  1  decode accepts; transfer occurs when `if_valid` and `id_ready` are both high.

Behaviour:
- Reset (async, active-high) sets: state=IDLE, `imem_req`=0, `addr_q`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, pend_valid=0.
- `pc_next`=RESET_PC while reset is high. Reset must span at least one clk edge so the PC register loads RESET_PC.
- Default `pc_next`=`pc_cur` (PC holds); overrides are listed below.
- slot_free = !`if_valid` || `id_ready`. A transfer with no new data in that cycle clears `if_valid`.
- States: IDLE, FETCH, STALL, DRAIN. `imem_req`=1 exactly in FETCH and DRAIN. Invariant in FETCH: `addr_q`==`pc_cur`.
- IDLE: go to FETCH next cycle; `addr_q`<=`pc_next`.
- FETCH, no ack: stay in FETCH.
- FETCH, ack, slot_free:
  - `if_instr`<=`imem_rdata`, `if_pc`<=`addr_q`, `if_valid`<=1.
  - `pc_next`=`addr_q`+PC_STEP; `addr_q`<=`pc_next`; stay in FETCH (back-to-back fetch, zero bubble).
- FETCH, ack, !slot_free: capture rdata/`addr_q` into pending register (pend_valid<=1), advance PC as above, go to STALL.
- STALL: `imem_req`=0. On `id_ready`: output <= pending, pend_valid<=0, go to FETCH with `addr_q`<=`pc_cur`.
- Branch (`branch_taken`=1) has priority over everything in the same cycle:
  - `pc_next`=`branch_target`; `if_valid`<=0; pend_valid<=0; same-cycle `id_ready` is ignored.
  - From IDLE/STALL: go to FETCH with `addr_q`<=`branch_target`.
  - From FETCH with ack this cycle: discard rdata, go to FETCH with `addr_q`<=`branch_target`.
  - From FETCH without ack: go to DRAIN; `addr_q` and `imem_req` stay unchanged (protocol holds).
  - In DRAIN: another branch updates `pc_next` only and remains in DRAIN.
- DRAIN: hold PC. On ack, discard rdata, go to FETCH with `addr_q`<=`pc_cur`; a branch in the same cycle instead uses `branch_target`.
- Arithmetic: `pc_next` is computed modulo 2^ADDR_W; 16'hFFFF+1 wraps to 16'h0000 with no flag.
- Reset mid-request: `imem_req` drops immediately (async). The memory must abort on reset; an ack arriving during reset is ignored.
- Latency: instruction at address A is presented on `if_*` in the cycle after its ack.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, FETCH, STALL, DRAIN}.
  - ADDR_W/INSTR_W defaults, RESET_PC, PC_STEP constants.
- One natural sub-module, fetch_outbuf: the output register plus one-entry pending register with the valid/ready logic.
- The FSM and `pc_next` mux stay in fetch_ctrl.

Test Plan:
- Reset held 2 cycles, memory acks every request the cycle after req rises, `id_ready`=1 → `imem_addr` 0,1,2,3; `if_pc` 0,1,2 on consecutive valid cycles; `pc_next` never skips.
- Memory latency 3 cycles → `imem_addr` and `imem_req` stable for 3 cycles; PC holds; each instruction is presented exactly once.
- `id_ready`=0 from cycle 5 for 4 cycles → one instruction held on `if_*`, the next in pending, `imem_req` low; on release both are delivered in order with no duplicates or losses.
- `branch_taken` with target 16'h0040 while a request to 0x0007 is outstanding (ack 2 cycles later) → DRAIN, 0x0007 data discarded, next `imem_addr`=0x0040, first `if_pc`=0x0040.
- `branch_taken` in the same cycle as ack and as `id_ready` → `if_valid`=0 next cycle; rdata dropped; `addr_q`=target.
- PC at 16'hFFFF, ack → `if_pc`=FFFF; next `imem_addr`=0000. Async reset asserted mid-FETCH → `imem_req`/`if_valid` low immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch controller.
package fetch_pkg;

    localparam int unsigned      FETCH_ADDR_W   = 16;
    localparam int unsigned      FETCH_INSTR_W  = 16;
    localparam int unsigned      FETCH_PC_STEP  = 1;
    localparam logic [15:0]      FETCH_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_outbuf.sv
// Output register towards decode plus a one-entry pending slot that catches
// an instruction returned while decode is still holding the previous one.
module fetch_outbuf
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = FETCH_ADDR_W,
    parameter int unsigned INSTR_W = FETCH_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               load,
    input  logic               stash,
    input  logic               pend_release,
    input  logic               id_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               slot_free
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               pend_valid_q, pend_valid_d;
    logic [INSTR_W-1:0] pend_instr_q, pend_instr_d;
    logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;

    assign slot_free = !valid_q || id_ready;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = pc_q;

    // A flush beats everything, including a same-cycle handshake from decode.
    always_comb begin
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_instr_d = pend_instr_q;
        pend_pc_d    = pend_pc_q;
        if (flush) begin
            valid_d      = 1'b0;
            pend_valid_d = 1'b0;
        end else if (pend_release) begin
            valid_d      = 1'b1;
            instr_d      = pend_instr_q;
            pc_d         = pend_pc_q;
            pend_valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = in_instr;
            pc_d    = in_pc;
        end else begin
            if (stash) begin
                pend_valid_d = 1'b1;
                pend_instr_d = in_instr;
                pend_pc_d    = in_pc;
            end
            if (valid_q && id_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc_q         <= '0;
            pend_valid_q <= 1'b0;
            pend_instr_q <= '0;
            pend_pc_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_instr_q <= pend_instr_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the PC register input, runs the
// req/ack memory protocol and hands instructions to decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
    parameter int unsigned       PC_STEP  = FETCH_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_cur,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_next_c;
    logic [ADDR_W-1:0] pc_inc;
    logic              slot_free;
    logic              buf_load;
    logic              buf_stash;
    logic              buf_release;

    assign pc_inc    = addr_q + ADDR_W'(PC_STEP);
    assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr = addr_q;
    assign pc_next   = pc_next_c;

    // A branch without an ack leaves the request untouched (DRAIN) so the
    // memory protocol is never violated; the stale data is dropped on ack.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pc_next_c   = pc_cur;
        buf_load    = 1'b0;
        buf_stash   = 1'b0;
        buf_release = 1'b0;
        if (reset) begin
            pc_next_c = RESET_PC;
        end else if (branch_taken) begin
            pc_next_c = branch_target;
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        addr_d = branch_target;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_d = FETCH;
                        addr_d  = branch_target;
                    end
                end
                default: begin
                    state_d = FETCH;
                    addr_d  = branch_target;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    addr_d  = pc_cur;
                end
                FETCH: begin
                    if (imem_ack) begin
                        pc_next_c = pc_inc;
                        addr_d    = pc_inc;
                        if (slot_free) begin
                            buf_load = 1'b1;
                        end else begin
                            buf_stash = 1'b1;
                            state_d   = STALL;
                        end
                    end
                end
                STALL: begin
                    if (id_ready) begin
                        buf_release = 1'b1;
                        state_d     = FETCH;
                        addr_d      = pc_cur;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_d = FETCH;
                        addr_d  = pc_cur;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    fetch_outbuf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_outbuf (
        .clk          (clk),
        .reset        (reset),
        .flush        (branch_taken),
        .load         (buf_load),
        .stash        (buf_stash),
        .pend_release (buf_release),
        .id_ready     (id_ready),
        .in_instr     (imem_rdata),
        .in_pc        (addr_q),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .slot_free    (slot_free)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the PC register and a fixed-latency
// instruction memory, and checks the decode-side stream per scenario.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] pc_reg;
    logic [15:0] pc_next;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready;

    int          lat;
    int          mem_cnt;
    int          tests_run;
    int          tests_failed;
    logic [15:0] got_pc[$];
    logic [15:0] got_instr[$];

    fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .pc_cur        (pc_reg),
        .pc_next       (pc_next),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .id_ready      (id_ready)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) pc_reg <= pc_next;

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory acks after `lat` wait cycles of a continuously held request.
    task automatic mem_update();
        if (reset || !imem_req) begin
            imem_ack = 1'b0;
            mem_cnt  = 0;
        end else if (mem_cnt == lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_data(imem_addr);
            mem_cnt    = 0;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 16'hDEAD;
            mem_cnt++;
        end
    endtask

    task automatic cycle();
        if (if_valid && id_ready && !branch_taken) begin
            got_pc.push_back(if_pc);
            got_instr.push_back(if_instr);
        end
        @(posedge clk);
        #1;
        mem_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        branch_taken = 1'b0;
        branch_target = 16'h0000;
        id_ready = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        got_pc.delete();
        got_instr.delete();
        #1;
    endtask

    task automatic test_reset();
        lat = 1;
        reset = 1'b1;
        cycle();
        cycle();
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", if_valid); end
        tests_run++; if (if_pc !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_if_pc: got %h expected 0000", if_pc); end
        tests_run++; if (if_instr !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_if_instr: got %h expected 0000", if_instr); end
        tests_run++; if (imem_addr !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_addr: got %h expected 0000", imem_addr); end
        tests_run++; if (pc_next !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_pc_next: got %h expected 0000", pc_next); end
        tests_run++; if (pc_reg !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_pc_reg: got %h expected 0000", pc_reg); end
        reset = 1'b0;
        id_ready = 1'b1;
        #1;
        cycle();
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin tests_failed++; $display("[TB] FAIL first_req: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        logic [15:0] addr_log[$];
        lat = 1;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            cycle();
            tests_run++; if (pc_next !== pc_reg && pc_next !== pc_reg + 16'd1) begin tests_failed++; $display("[TB] FAIL seq_pc_step: got pc_next=%h expected %h or %h", pc_next, pc_reg, pc_reg + 16'd1); end
            if (imem_req && (addr_log.size() == 0 || addr_log[$] !== imem_addr)) addr_log.push_back(imem_addr);
        end
        tests_run++; if (addr_log.size() < 4) begin tests_failed++; $display("[TB] FAIL seq_addr_count: got %0d expected >=4", addr_log.size()); end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            tests_run++; if (addr_log[i] !== 16'(i)) begin tests_failed++; $display("[TB] FAIL seq_addr[%0d]: got %h expected %h", i, addr_log[i], 16'(i)); end
        end
        tests_run++; if (got_pc.size() != 4) begin tests_failed++; $display("[TB] FAIL seq_xfer_count: got %0d expected 4", got_pc.size()); end
        for (int i = 0; i < got_pc.size() && i < 4; i++) begin
            tests_run++; if (got_pc[i] !== 16'(i) || got_instr[i] !== mem_data(16'(i))) begin tests_failed++; $display("[TB] FAIL seq_xfer[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", i, got_pc[i], got_instr[i], 16'(i), mem_data(16'(i))); end
        end
    endtask

    task automatic test_latency();
        int hold;
        lat = 3;
        do_reset();
        hold = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (imem_req && !imem_ack) begin
                hold++;
                tests_run++; if (imem_addr !== pc_reg || pc_next !== pc_reg) begin tests_failed++; $display("[TB] FAIL lat_hold: got addr=%h pc_next=%h expected both %h", imem_addr, pc_next, pc_reg); end
            end else if (imem_ack) begin
                tests_run++; if (hold != 3) begin tests_failed++; $display("[TB] FAIL lat_wait: got %0d expected 3", hold); end
                hold = 0;
            end
        end
        tests_run++; if (got_pc.size() != 4) begin tests_failed++; $display("[TB] FAIL lat_xfer_count: got %0d expected 4", got_pc.size()); end
        for (int i = 0; i < got_pc.size() && i < 4; i++) begin
            tests_run++; if (got_pc[i] !== 16'(i) || got_instr[i] !== mem_data(16'(i))) begin tests_failed++; $display("[TB] FAIL lat_xfer[%0d]: got pc=%h instr=%h expected pc=%h", i, got_pc[i], got_instr[i], 16'(i)); end
        end
    endtask

    task automatic test_stall();
        lat = 0;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            cycle();
            id_ready = (k < 5 || k > 8);
            if (k == 6) begin
                tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_req: got %b expected 0", imem_req); end
                tests_run++; if (if_valid !== 1'b1 || if_pc !== 16'h0003) begin tests_failed++; $display("[TB] FAIL stall_hold: got valid=%b pc=%h expected valid=1 pc=0003", if_valid, if_pc); end
                tests_run++; if (pc_reg !== 16'h0005) begin tests_failed++; $display("[TB] FAIL stall_pc: got %h expected 0005", pc_reg); end
            end
            if (k == 10) begin
                tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin tests_failed++; $display("[TB] FAIL stall_resume: got req=%b addr=%h expected req=1 addr=0005", imem_req, imem_addr); end
            end
        end
        tests_run++; if (got_pc.size() != 8) begin tests_failed++; $display("[TB] FAIL stall_xfer_count: got %0d expected 8", got_pc.size()); end
        for (int i = 0; i < got_pc.size() && i < 8; i++) begin
            tests_run++; if (got_pc[i] !== 16'(i) || got_instr[i] !== mem_data(16'(i))) begin tests_failed++; $display("[TB] FAIL stall_xfer[%0d]: got pc=%h instr=%h expected pc=%h", i, got_pc[i], got_instr[i], 16'(i)); end
        end
    endtask

    task automatic test_branch_drain();
        lat = 2;
        do_reset();
        branch_taken = 1'b1;
        branch_target = 16'h0007;
        #1;
        tests_run++; if (pc_next !== 16'h0007) begin tests_failed++; $display("[TB] FAIL br_idle_pc_next: got %h expected 0007", pc_next); end
        cycle();
        branch_target = 16'h0040;
        #1;
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0007 || pc_next !== 16'h0040) begin tests_failed++; $display("[TB] FAIL br_issue: got req=%b addr=%h pc_next=%h expected 1 0007 0040", imem_req, imem_addr, pc_next); end
        cycle();
        branch_taken = 1'b0;
        #1;
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0007 || pc_next !== 16'h0040) begin tests_failed++; $display("[TB] FAIL br_drain_hold: got req=%b addr=%h pc_next=%h expected 1 0007 0040", imem_req, imem_addr, pc_next); end
        cycle();
        tests_run++; if (imem_ack !== 1'b1 || imem_addr !== 16'h0007) begin tests_failed++; $display("[TB] FAIL br_drain_ack: got ack=%b addr=%h expected 1 0007", imem_ack, imem_addr); end
        cycle();
        tests_run++; if (imem_addr !== 16'h0040 || if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL br_redirect: got addr=%h valid=%b expected 0040 0", imem_addr, if_valid); end
        for (int k = 5; k <= 8; k++) cycle();
        tests_run++; if (got_pc.size() != 1) begin tests_failed++; $display("[TB] FAIL br_drain_count: got %0d expected 1", got_pc.size()); end
        if (got_pc.size() > 0) begin
            tests_run++; if (got_pc[0] !== 16'h0040 || got_instr[0] !== mem_data(16'h0040)) begin tests_failed++; $display("[TB] FAIL br_drain_first: got pc=%h instr=%h expected pc=0040 instr=%h", got_pc[0], got_instr[0], mem_data(16'h0040)); end
        end
    endtask

    task automatic test_branch_ack();
        lat = 0;
        do_reset();
        cycle();
        cycle();
        cycle();
        branch_taken = 1'b1;
        branch_target = 16'h0100;
        #1;
        tests_run++; if (imem_ack !== 1'b1 || if_valid !== 1'b1 || pc_next !== 16'h0100) begin tests_failed++; $display("[TB] FAIL bra_setup: got ack=%b valid=%b pc_next=%h expected 1 1 0100", imem_ack, if_valid, pc_next); end
        cycle();
        branch_taken = 1'b0;
        #1;
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bra_flush: got %b expected 0", if_valid); end
        tests_run++; if (imem_addr !== 16'h0100 || pc_reg !== 16'h0100) begin tests_failed++; $display("[TB] FAIL bra_target: got addr=%h pc=%h expected 0100 0100", imem_addr, pc_reg); end
        cycle();
        tests_run++; if (if_valid !== 1'b1 || if_pc !== 16'h0100 || if_instr !== mem_data(16'h0100)) begin tests_failed++; $display("[TB] FAIL bra_first: got valid=%b pc=%h instr=%h expected 1 0100 %h", if_valid, if_pc, if_instr, mem_data(16'h0100)); end
        cycle();
        tests_run++; if (got_pc.size() != 2) begin tests_failed++; $display("[TB] FAIL bra_count: got %0d expected 2", got_pc.size()); end
        if (got_pc.size() == 2) begin
            tests_run++; if (got_pc[0] !== 16'h0000 || got_pc[1] !== 16'h0100) begin tests_failed++; $display("[TB] FAIL bra_order: got %h,%h expected 0000,0100", got_pc[0], got_pc[1]); end
        end
    endtask

    task automatic test_wrap_and_reset();
        lat = 0;
        do_reset();
        branch_taken = 1'b1;
        branch_target = 16'hFFFF;
        cycle();
        branch_taken = 1'b0;
        #1;
        tests_run++; if (imem_addr !== 16'hFFFF || imem_ack !== 1'b1 || pc_next !== 16'h0000) begin tests_failed++; $display("[TB] FAIL wrap_next: got addr=%h ack=%b pc_next=%h expected FFFF 1 0000", imem_addr, imem_ack, pc_next); end
        cycle();
        tests_run++; if (if_valid !== 1'b1 || if_pc !== 16'hFFFF || if_instr !== mem_data(16'hFFFF)) begin tests_failed++; $display("[TB] FAIL wrap_out: got valid=%b pc=%h instr=%h expected 1 FFFF %h", if_valid, if_pc, if_instr, mem_data(16'hFFFF)); end
        tests_run++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_addr: got req=%b addr=%h expected 1 0000", imem_req, imem_addr); end
        reset = 1'b1;
        #1;
        tests_run++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_reset: got req=%b valid=%b expected 0 0", imem_req, if_valid); end
        tests_run++; if (pc_next !== 16'h0000) begin tests_failed++; $display("[TB] FAIL async_reset_pc: got %h expected 0000", pc_next); end
        cycle();
        imem_ack = 1'b1;
        imem_rdata = 16'hBEEF;
        cycle();
        reset = 1'b0;
        #1;
        tests_run++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || pc_reg !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_release: got valid=%b req=%b pc=%h expected 0 0 0000", if_valid, imem_req, pc_reg); end
        cycle();
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin tests_failed++; $display("[TB] FAIL restart_addr: got req=%b addr=%h expected 1 0000", imem_req, imem_addr); end
        cycle();
        tests_run++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== mem_data(16'h0000)) begin tests_failed++; $display("[TB] FAIL restart_out: got valid=%b pc=%h instr=%h expected 1 0000 %h", if_valid, if_pc, if_instr, mem_data(16'h0000)); end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 16'h0000;
        branch_taken = 1'b0;
        branch_target = 16'h0000;
        id_ready = 1'b0;
        lat = 1;
        mem_cnt = 0;
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_sequential();
        test_latency();
        test_stall();
        test_branch_drain();
        test_branch_ack();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
